// File: rtl/pcie_os_sched_if.sv
// Handshake bundle between the LTSSM / rx driver side and the per-lane ordered-set scheduler.
interface pcie_os_sched_if;
    logic       start;
    logic       abort;
    logic       os_done;
    logic       rx_ts1;
    logic       rx_ts2;
    logic       rx_bad;
    logic [5:0] ost;
    logic       en_n;
    logic       done;
    logic       timeout;
    logic [2:0] state;

    modport master (
        output start, abort, os_done, rx_ts1, rx_ts2, rx_bad,
        input  ost, en_n, done, timeout, state
    );

    modport slave (
        input  start, abort, os_done, rx_ts1, rx_ts2, rx_bad,
        output ost, en_n, done, timeout, state
    );
endinterface

// File: rtl/pcie_os_sched.sv
// Per-lane Polling ordered-set scheduler: TS1 -> TS2 -> logical idle with timeout.
// Optional SKP insertion is compiled in when OZPHY_SKP_INSERT_EN is defined.
module pcie_os_sched #(
    parameter int unsigned TS1_MIN      = 1024,
    parameter int unsigned RX_REQ       = 8,
    parameter int unsigned TX_TS2_POST  = 16,
    parameter int unsigned SKP_INTERVAL = 1180,
    parameter int unsigned TIMEOUT_CYC  = 24000
) (
    input  logic             clk,
    input  logic             reset_n,
    pcie_os_sched_if.slave   bus
);
    localparam logic [5:0] OST_NONE = 6'd0;
    localparam logic [5:0] OST_IDLE = 6'd1;
    localparam logic [5:0] OST_TS1  = 6'd2;
    localparam logic [5:0] OST_TS2  = 6'd3;
    localparam int TX2_W = $clog2(TX_TS2_POST + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TS1  = 3'd1,
        S_TS2  = 3'd2,
        S_DONE = 3'd3
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         ost_q, ost_d;
    logic               en_n_q, en_n_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic [10:0]        tx1_cnt_q, tx1_cnt_d;
    logic [TX2_W-1:0]   tx2_cnt_q, tx2_cnt_d;
    logic [3:0]         rx_cnt_q, rx_cnt_d;
    logic               rx_ok_q, rx_ok_d;
    logic [15:0]        tmr_q, tmr_d;

    logic [3:0]         rx_inc;
    logic               rx_enough;
    logic               skp_set;
    logic               set_end;
    logic               adv;

`ifdef OZPHY_SKP_INSERT_EN
    localparam logic [5:0] OST_SKP = 6'd4;
    localparam int SKP_W = $clog2(SKP_INTERVAL + 1);

    logic [SKP_W-1:0]   skp_tmr_q, skp_tmr_d;
    logic               skp_pend_q, skp_pend_d;

    assign skp_set = (ost_q == OST_SKP);
`else
    assign skp_set = 1'b0;
`endif

    // Code to resume after an inserted SKP set.
    function automatic logic [5:0] base_ost(input state_e s);
        case (s)
            S_TS1:   base_ost = OST_TS1;
            S_TS2:   base_ost = OST_TS2;
            S_DONE:  base_ost = OST_IDLE;
            default: base_ost = OST_NONE;
        endcase
    endfunction

    assign rx_inc    = (rx_cnt_q == 4'hF) ? rx_cnt_q : rx_cnt_q + 4'd1;
    assign rx_enough = (32'(rx_cnt_q) >= RX_REQ);
    // Only completed TS sets count; an inserted SKP set is transparent.
    assign set_end   = bus.os_done && !skp_set;

    always_comb begin
        state_d   = state_q;
        ost_d     = ost_q;
        en_n_d    = en_n_q;
        done_d    = done_q;
        timeout_d = 1'b0;
        tx1_cnt_d = tx1_cnt_q;
        tx2_cnt_d = tx2_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        rx_ok_d   = rx_ok_q;
        tmr_d     = tmr_q;
        adv       = 1'b0;
`ifdef OZPHY_SKP_INSERT_EN
        skp_tmr_d  = skp_tmr_q;
        skp_pend_d = skp_pend_q;
`endif

        case (state_q)
            S_TS1: begin
                if (bus.rx_bad)
                    rx_cnt_d = 4'd0;
                else if (bus.rx_ts1 || bus.rx_ts2)
                    rx_cnt_d = rx_inc;
                if (set_end) begin
                    tx1_cnt_d = (tx1_cnt_q == '1) ? tx1_cnt_q : tx1_cnt_q + 11'd1;
                    if ((32'(tx1_cnt_q) + 32'd1 >= TS1_MIN) && rx_enough) begin
                        adv       = 1'b1;
                        state_d   = S_TS2;
                        ost_d     = OST_TS2;
                        rx_cnt_d  = 4'd0;
                        rx_ok_d   = 1'b0;
                        tx2_cnt_d = '0;
                    end
                end
            end
            S_TS2: begin
                if (bus.rx_ts1 || bus.rx_bad)
                    rx_cnt_d = 4'd0;
                else if (bus.rx_ts2)
                    rx_cnt_d = rx_inc;
                if (rx_enough)
                    rx_ok_d = 1'b1;
                if (set_end && rx_ok_q) begin
                    tx2_cnt_d = tx2_cnt_q + TX2_W'(1);
                    if (32'(tx2_cnt_q) + 32'd1 >= TX_TS2_POST) begin
                        adv     = 1'b1;
                        state_d = S_DONE;
                        ost_d   = OST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase

`ifdef OZPHY_SKP_INSERT_EN
        // A state change on this os_done keeps the SKP pending for the following set.
        if (bus.os_done && state_q != S_IDLE) begin
            if (skp_set)
                ost_d = base_ost(state_q);
            else if (skp_pend_q && !adv) begin
                ost_d      = OST_SKP;
                skp_pend_d = 1'b0;
            end
        end
        if (!en_n_q) begin
            if (skp_tmr_q == SKP_W'(SKP_INTERVAL - 1)) begin
                skp_tmr_d  = '0;
                skp_pend_d = 1'b1;
            end else begin
                skp_tmr_d = skp_tmr_q + SKP_W'(1);
            end
        end
`endif

        // Timer spans TS1 and TS2; an advance on the expiry cycle takes precedence.
        if (state_q == S_TS1 || state_q == S_TS2) begin
            tmr_d = tmr_q + 16'd1;
            if (tmr_q == 16'(TIMEOUT_CYC - 1) && !adv) begin
                state_d   = S_IDLE;
                ost_d     = OST_NONE;
                en_n_d    = 1'b1;
                done_d    = 1'b0;
                timeout_d = 1'b1;
`ifdef OZPHY_SKP_INSERT_EN
                skp_pend_d = 1'b0;
                skp_tmr_d  = '0;
`endif
            end
        end

        if ((state_q == S_IDLE || state_q == S_DONE) && bus.start) begin
            state_d   = S_TS1;
            ost_d     = OST_TS1;
            en_n_d    = 1'b0;
            done_d    = 1'b0;
            tx1_cnt_d = '0;
            tx2_cnt_d = '0;
            rx_cnt_d  = 4'd0;
            rx_ok_d   = 1'b0;
            tmr_d     = 16'd0;
`ifdef OZPHY_SKP_INSERT_EN
            skp_tmr_d  = '0;
            skp_pend_d = 1'b0;
`endif
        end

        if (bus.abort) begin
            state_d   = S_IDLE;
            ost_d     = OST_NONE;
            en_n_d    = 1'b1;
            done_d    = 1'b0;
            timeout_d = 1'b0;
`ifdef OZPHY_SKP_INSERT_EN
            skp_tmr_d  = '0;
            skp_pend_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ost_q     <= OST_NONE;
            en_n_q    <= 1'b1;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            tx1_cnt_q <= '0;
            tx2_cnt_q <= '0;
            rx_cnt_q  <= 4'd0;
            rx_ok_q   <= 1'b0;
            tmr_q     <= 16'd0;
`ifdef OZPHY_SKP_INSERT_EN
            skp_tmr_q  <= '0;
            skp_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ost_q     <= ost_d;
            en_n_q    <= en_n_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            tx1_cnt_q <= tx1_cnt_d;
            tx2_cnt_q <= tx2_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_ok_q   <= rx_ok_d;
            tmr_q     <= tmr_d;
`ifdef OZPHY_SKP_INSERT_EN
            skp_tmr_q  <= skp_tmr_d;
            skp_pend_q <= skp_pend_d;
`endif
        end
    end

    assign bus.ost     = ost_q;
    assign bus.en_n    = en_n_q;
    assign bus.done    = done_q;
    assign bus.timeout = timeout_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_pcie_os_sched.sv
// Directed bench for pcie_os_sched with small parameters; os_done every 16 clocks.
module tb_pcie_os_sched;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int ph = 0;
    bit saw4 = 1'b0;
    logic last_od;
    logic [5:0] last_ost;

    pcie_os_sched_if bus ();

    pcie_os_sched #(
        .TS1_MIN(4), .RX_REQ(2), .TX_TS2_POST(3), .SKP_INTERVAL(40), .TIMEOUT_CYC(200)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive pulses, os_done on phase 15, sample 1 time unit after the edge.
    task automatic cyc(input bit s = 0, input bit a = 0, input bit t1 = 0,
                       input bit t2 = 0, input bit b = 0);
        bus.start   = s;
        bus.abort   = a;
        bus.rx_ts1  = t1;
        bus.rx_ts2  = t2;
        bus.rx_bad  = b;
        bus.os_done = (ph == 15);
        last_od  = bus.os_done;
        last_ost = bus.ost;
        @(posedge clk);
        #1;
        ph = s ? 0 : (ph + 1) % 16;
        bus.start = 0; bus.abort = 0; bus.rx_ts1 = 0; bus.rx_ts2 = 0;
        bus.rx_bad = 0; bus.os_done = 0;
        if (bus.ost == 6'd4) saw4 = 1'b1;
    endtask

    // Run until n sets carrying the given code have completed.
    task automatic wait_sets(input int n, input logic [5:0] code, input string tag);
        int seen = 0;
        int k = 0;
        while (seen < n && k < 400) begin
            cyc();
            if (last_od && last_ost == code) seen++;
            k++;
        end
        chk(tag, seen, n);
    endtask

    task automatic to_od();
        while (ph != 15) cyc();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 0; bus.abort = 0; bus.os_done = 0;
        bus.rx_ts1 = 0; bus.rx_ts2 = 0; bus.rx_bad = 0;

        // 1: reset values, idle with os_done ignored, start
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", bus.state, 0);
        chk("rst_ost", bus.ost, 0);
        chk("rst_en_n", bus.en_n, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_timeout", bus.timeout, 0);
        reset_n = 1'b1;
        repeat (20) cyc();
        chk("idle_state", bus.state, 0);
        chk("idle_ost", bus.ost, 0);
        chk("idle_en_n", bus.en_n, 1);
        cyc(.s(1));
        chk("start_ost", bus.ost, 2);
        chk("start_en_n", bus.en_n, 0);
        chk("start_state", bus.state, 1);

        // 2: full path to DONE
        cyc(.t1(1));
        cyc(.t1(1));
        wait_sets(3, 6'd2, "p_ts1x3");
        chk("p_still_ts1", bus.state, 1);
        wait_sets(1, 6'd2, "p_ts1x4");
        chk("p_ts2_state", bus.state, 2);
        chk("p_ts2_ost", bus.ost, 3);
        cyc(.t2(1));
        cyc(.t2(1));
        wait_sets(2, 6'd3, "p_ts2x2");
        chk("p_ts2_hold", bus.state, 2);
        chk("p_ts2_done0", bus.done, 0);
        wait_sets(1, 6'd3, "p_ts2x3");
        chk("p_done_state", bus.state, 3);
        chk("p_done", bus.done, 1);
        chk("p_done_ost", bus.ost, 1);
        chk("p_done_en_n", bus.en_n, 0);
        repeat (20) cyc();
        chk("p_done_hold", bus.done, 1);

        // 3: rx_bad breaks the run of TS1; restart from DONE
        cyc(.s(1));
        chk("r_state", bus.state, 1);
        chk("r_ost", bus.ost, 2);
        chk("r_done", bus.done, 0);
        cyc(.t1(1));
        cyc(.b(1));
        cyc(.t1(1));
        cyc(.t1(1), .b(1));
        wait_sets(4, 6'd2, "b_ts1x4");
        chk("b_ts1_after4", bus.state, 1);
        wait_sets(1, 6'd2, "b_ts1x5");
        chk("b_ts1_after5", bus.state, 1);
        cyc(.t1(1));
        cyc(.t1(1));
        wait_sets(1, 6'd2, "b_ts1x6");
        chk("b_adv", bus.state, 2);
        cyc(.a(1));
        chk("b_abort_state", bus.state, 0);
        chk("b_abort_en_n", bus.en_n, 1);

        // 4: timeout with no rx traffic
        cyc(.s(1));
        repeat (199) cyc();
        chk("t_pre_state", bus.state, 1);
        chk("t_pre_timeout", bus.timeout, 0);
        cyc();
        chk("t_timeout", bus.timeout, 1);
        chk("t_state", bus.state, 0);
        chk("t_en_n", bus.en_n, 1);
        chk("t_ost", bus.ost, 0);
        cyc();
        chk("t_pulse_end", bus.timeout, 0);

        // 5: abort + start + os_done together in TS2
        cyc(.s(1));
        cyc(.t1(1));
        cyc(.t1(1));
        wait_sets(4, 6'd2, "a_ts1x4");
        chk("a_in_ts2", bus.state, 2);
        cyc(.t2(1));
        to_od();
        cyc(.s(1), .a(1));
        chk("a_state", bus.state, 0);
        chk("a_ost", bus.ost, 0);
        chk("a_done", bus.done, 0);
        chk("a_en_n", bus.en_n, 1);
        cyc();
        chk("a_stay_idle", bus.state, 0);

`ifdef OZPHY_SKP_INSERT_EN
        // 6: SKP set after 40 enabled cycles, TS1 exit slips by one set
        cyc(.s(1));
        cyc(.t1(1));
        cyc(.t1(1));
        repeat (45) cyc();
        chk("s_pre_ost", bus.ost, 2);
        cyc();
        chk("s_skp_ost", bus.ost, 4);
        repeat (15) cyc();
        chk("s_skp_hold", bus.ost, 4);
        cyc();
        chk("s_restore_ost", bus.ost, 2);
        chk("s_slip_state", bus.state, 1);
        repeat (16) cyc();
        chk("s_adv_state", bus.state, 2);
        cyc(.a(1));
`else
        chk("no_skp_code", saw4, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
